// File: rtl/apu_upsample_sequencer_pkg.sv
// Shared APU upsampler constants and types.
// Ratio, phase width and sample width for the 8x zero-stuffing path.
package apu_upsample_sequencer_pkg;

  localparam int APU_UPSAMPLE_RATIO   = 8;
  localparam int APU_UPSAMPLE_PHASE_W = 3;
  localparam int APU_SAMPLE_W         = 16;

  typedef logic [APU_UPSAMPLE_PHASE_W-1:0] phase_t;
  typedef logic [APU_SAMPLE_W-1:0]         sample_t;

  function automatic logic is_frame_start(phase_t p);
    return p == '0;
  endfunction

endpackage

// File: rtl/apu_strobe_div.sv
// Programmable strobe divider: tick_nxt every div+1 clocks while enabled.
// Ports: clk, rst (sync, high), enable, div (reload), tick_nxt (comb).
module apu_strobe_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick_nxt
);

  logic [DIV_W-1:0] cnt;

  assign tick_nxt = enable && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/apu_upsample_sequencer.sv
// 8x upsampler sequencer: strobes the FIR, stuffs zeroes, republishes output.
// Ports: clk, rst, enable, div, in_* handshake, filt_* FIR side, out_*, flags.
module apu_upsample_sequencer
  import apu_upsample_sequencer_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             filt_en,
  output logic [15:0]      filt_d,
  input  logic [15:0]      filt_q,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             frame_tick,
  output logic             underflow,
  input  logic             clr_underflow
);

  logic    tick;
  phase_t  phase;
  sample_t hold;
  sample_t last;
  logic    hold_valid;
  logic    ph0;
  sample_t filt_d_nxt;
  logic    consume;
  logic    uf_set;
  logic    accept;

  apu_strobe_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .div      (div),
    .tick_nxt (tick)
  );

  assign in_ready = !hold_valid;
  assign accept   = in_valid && in_ready;
  assign out_data = filt_q;
  assign ph0      = is_frame_start(phase);

  // Phase 0 takes the held sample, or repeats
  // the last one on starvation to avoid a click.
  always_comb begin
    filt_d_nxt = filt_d;
    consume    = 1'b0;
    uf_set     = 1'b0;
    unique case (1'b1)
      !tick: ;
      tick && !ph0: filt_d_nxt = '0;
      tick && ph0 && hold_valid: begin
        filt_d_nxt = hold;
        consume    = 1'b1;
      end
      default: begin
        filt_d_nxt = last;
        uf_set     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      last       <= '0;
      filt_en    <= 1'b0;
      filt_d     <= '0;
      frame_tick <= 1'b0;
      out_valid  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      filt_en    <= tick;
      frame_tick <= tick && ph0;
      out_valid  <= filt_en;
      filt_d     <= filt_d_nxt;

      if (!enable) begin
        phase <= '0;
      end else if (tick) begin
        phase <= phase + phase_t'(1);
      end

      if (accept) begin
        hold       <= in_data;
        hold_valid <= 1'b1;
      end else if (consume) begin
        last       <= hold;
        hold_valid <= 1'b0;
      end

      if (uf_set) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_upsample_sequencer.sv
// Bench for apu_upsample_sequencer: vector table, directed sequences,
// and random stimulus against a strobe-count reference model.
module tb_apu_upsample_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  div = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        filt_en;
  logic [15:0] filt_d;
  logic [15:0] filt_q = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        frame_tick;
  logic        underflow;
  logic        clr_underflow = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apu_upsample_sequencer #(.DIV_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .div           (div),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .filt_en       (filt_en),
    .filt_d        (filt_d),
    .filt_q        (filt_q),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .frame_tick    (frame_tick),
    .underflow     (underflow),
    .clr_underflow (clr_underflow)
  );

  // Reference model: mk counts consecutive enabled cycles;
  // strobe s happens at mk = s*(div+1), its phase is s mod 8.
  int          mk;
  bit          m_hv, m_fe, m_ft, m_ov, m_uf;
  logic [15:0] m_hold, m_last, m_fd;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick, set, acc;
    int per, ph;
    if (rst) begin
      mk = 0; m_hv = 0; m_hold = 0; m_last = 0; m_fd = 0;
      m_fe = 0; m_ft = 0; m_ov = 0; m_uf = 0;
    end else begin
      per  = int'(div) + 1;
      tick = enable && (mk % per == 0);
      ph   = (mk / per) % 8;
      set  = 0;
      acc  = in_valid && !m_hv;
      m_ov = m_fe;
      m_fe = tick;
      m_ft = tick && ph == 0;
      if (tick) begin
        if (ph != 0) m_fd = 0;
        else if (m_hv) begin
          m_fd = m_hold; m_last = m_hold; m_hv = 0;
        end else begin
          m_fd = m_last; set = 1;
        end
      end
      if (acc) begin
        m_hold = in_data; m_hv = 1;
      end
      if (set) m_uf = 1;
      else if (clr_underflow) m_uf = 0;
      mk = enable ? mk + 1 : 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("filt_en", filt_en, m_fe);
    chk("filt_d", filt_d, m_fd);
    chk("frame_tick", frame_tick, m_ft);
    chk("out_valid", out_valid, m_ov);
    chk("underflow", underflow, m_uf);
    chk("in_ready", in_ready, !m_hv);
    chk("out_data", out_data, filt_q);
  endtask

  typedef struct {
    logic        rst, en, iv, clr;
    logic [7:0]  div;
    logic [15:0] d;
    logic        fe, ft, ov, uf, rdy;
    logic [15:0] fd;
  } vec_t;

  vec_t vt[14];

  initial begin
    int n, first_i, supplied, timeout;
    logic [15:0] seq_d[$];
    bit          seq_f[$];
    int          seq_i[$];
    logic [15:0] exp_d;

    //        rst en iv clr div  d        fe ft ov uf rdy fd
    vt[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000};
    vt[1]  = '{0, 0, 1, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 16'h0000};
    vt[2]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h1234};
    vt[3]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h0000};
    vt[4]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h0000};
    vt[5]  = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000};
    vt[6]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 1, 16'h1234};
    vt[7]  = '{0, 0, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h1234};
    vt[8]  = '{0, 0, 1, 0, 0, 16'h5555, 0, 0, 0, 0, 0, 16'h1234};
    vt[9]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000};
    vt[10] = '{0, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 1, 16'h0000};
    vt[11] = '{0, 1, 0, 1, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h0000};
    vt[12] = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000};
    vt[13] = '{0, 1, 0, 1, 0, 16'h0000, 1, 1, 0, 1, 1, 16'h0000};

    #2;
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; enable = vt[i].en; in_valid = vt[i].iv;
      clr_underflow = vt[i].clr; div = vt[i].div; in_data = vt[i].d;
      filt_q = 16'h0F0F;
      step();
      chk($sformatf("vec%0d.fe", i), filt_en, vt[i].fe);
      chk($sformatf("vec%0d.ft", i), frame_tick, vt[i].ft);
      chk($sformatf("vec%0d.ov", i), out_valid, vt[i].ov);
      chk($sformatf("vec%0d.od", i), out_data, 16'h0F0F);
      chk($sformatf("vec%0d.uf", i), underflow, vt[i].uf);
      chk($sformatf("vec%0d.rdy", i), in_ready, vt[i].rdy);
      chk($sformatf("vec%0d.fd", i), filt_d, vt[i].fd);
    end
    clr_underflow = 0;

    // Zero stuffing with div=3
    enable = 0; rst = 1; step(); rst = 0;
    div = 3; in_valid = 1; in_data = 16'h1234; step();
    in_valid = 0; enable = 1;
    first_i = -1; supplied = 0; timeout = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (in_valid) begin
        in_valid = 0; supplied = 1;
      end
      if (filt_en) begin
        if (first_i < 0) first_i = i;
        seq_d.push_back(filt_d);
        seq_f.push_back(frame_tick);
        seq_i.push_back(i);
      end
      if (seq_d.size() == 16) begin
        timeout = 0;
        break;
      end
      if (seq_d.size() >= 1 && !supplied && in_ready) begin
        in_valid = 1; in_data = 16'hABCD;
      end
    end
    chk("stuff.timeout", timeout, 0);
    chk("stuff.first", first_i, 0);
    if (!timeout) begin
      for (int j = 0; j < 16; j++) begin
        exp_d = (j == 0) ? 16'h1234 : (j == 8) ? 16'hABCD : 16'h0000;
        chk($sformatf("stuff.d%0d", j), seq_d[j], exp_d);
        chk($sformatf("stuff.ft%0d", j), seq_f[j], (j % 8) == 0);
        if (j > 0) chk($sformatf("stuff.gap%0d", j), seq_i[j] - seq_i[j-1], 4);
      end
    end

    // Mid-frame disable at phase 5, hold refilled before it
    enable = 0; rst = 1; step(); rst = 0;
    div = 1; in_valid = 1; in_data = 16'h7777; step();
    in_valid = 0; enable = 1; n = 0; timeout = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      in_valid = 0;
      if (filt_en) n++;
      if (n == 1 && in_ready) begin
        in_valid = 1; in_data = 16'h4242;
      end
      if (n == 5) begin
        timeout = 0;
        break;
      end
    end
    chk("mid.timeout", timeout, 0);
    in_valid = 0; enable = 0; step(); step();
    chk("mid.held", in_ready, 0);
    enable = 1; timeout = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (filt_en) begin
        timeout = 0;
        break;
      end
    end
    chk("mid.strobe", timeout, 0);
    chk("mid.frame", frame_tick, 1);
    chk("mid.data", filt_d, 16'h4242);
    chk("mid.uf", underflow, 0);

    // Random traffic against the model
    for (int seg = 0; seg < 40; seg++) begin
      enable = 0; in_valid = 0; clr_underflow = 0;
      div = 8'($urandom_range(0, 3));
      step();
      enable = 1;
      n = $urandom_range(4, 60);
      for (int c = 0; c < n; c++) begin
        in_valid = ($urandom % 4) == 0;
        in_data = 16'($urandom);
        filt_q = 16'($urandom);
        clr_underflow = ($urandom % 16) == 0;
        rst = ($urandom % 150) == 0;
        step();
        rst = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
